// File: rtl/seq_restoring_divider_if.sv
// Handshake bundle for the sequential restoring divider: operand request
// channel (valid/ready) and result channel (valid/ready).
interface seq_restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_zero;

  // Requester / result consumer side
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  // Divider side
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit
// divisor, one quotient bit per clock. Result registers are separate from the
// working registers so the last result holds steady while a new one is built.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      dvd_q, dvd_d;        // dividend, consumed MSB first
  logic [WIDTH-1:0]   dvs_q, dvs_d;        // latched divisor
  logic [WIDTH:0]     part_q, part_d;      // partial remainder
  logic [DW-1:0]      qwork_q, qwork_d;    // quotient under construction
  logic               zero_q, zero_d;      // current op is a divide by zero
  logic [DW-1:0]      quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;
  logic               q_bit;
  logic [WIDTH:0]     part_next;
  logic [DW-1:0]      qwork_next;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore
  always_comb begin
    // The partial remainder is always below the divisor, so its top bit is zero here
    shifted    = {part_q[WIDTH-1:0], dvd_q[DW-1]};
    trial      = {1'b0, shifted} - {2'b00, dvs_q};
    q_bit      = ~trial[WIDTH+1];
    part_next  = q_bit ? trial[WIDTH:0] : shifted;
    qwork_next = {qwork_q[DW-2:0], q_bit};
  end

  // Next-state and register updates for the IDLE/CALC/DONE sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    qwork_d     = qwork_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          part_d  = '0;
          qwork_d = '0;
          state_d = CALC;
          if (bus.divisor == '0) begin
            zero_d = 1'b1;
            cnt_d  = '0;
          end else begin
            zero_d = 1'b0;
            cnt_d  = CW'(DW - 1);
          end
        end
      end
      CALC: begin
        if (zero_q) begin
          // Divide by zero spends a single CALC cycle so its result appears one edge after accept
          quotient_d  = '1;
          remainder_d = dvd_q[WIDTH-1:0];
          div_zero_d  = 1'b1;
          state_d     = DONE;
        end else begin
          part_d  = part_next;
          qwork_d = qwork_next;
          dvd_d   = {dvd_q[DW-2:0], 1'b0};
          if (cnt_q == '0) begin
            quotient_d  = qwork_next;
            remainder_d = part_next[WIDTH-1:0];
            div_zero_d  = 1'b0;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      qwork_q     <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      part_q      <= part_d;
      qwork_q     <= qwork_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed-vector and random bench for seq_restoring_divider (WIDTH=8).
module tb_seq_restoring_divider;
  logic clk;
  logic rst_n;
  int   cmp_cnt;
  int   err_cnt;
  int   accepts;
  int   retires;

  seq_restoring_divider_if #(.WIDTH(8)) bus ();

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One full operation: wait idle, accept, count edges to out_valid, check, retire
  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                        input logic [15:0] eq, input logic [7:0] er, input logic edz,
                        input int elat, input bit chk_lat);
    int lat;
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    accepts++;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
    if (chk_lat) check("latency", 32'(lat), 32'(elat));
    check("quotient", 32'(bus.quotient), 32'(eq));
    check("remainder", 32'(bus.remainder), 32'(er));
    check("div_zero", 32'(bus.div_zero), 32'(edz));
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    $display("op %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d", dvd, dvs,
             bus.quotient, bus.remainder, bus.div_zero, lat);
    if (bus.out_ready) begin
      @(posedge clk); #1;
      check("retire_out_valid", 32'(bus.out_valid), 32'd0);
      check("retire_in_ready", 32'(bus.in_ready), 32'd1);
      if (!bus.out_valid) retires++;
    end
  endtask

  initial begin
    logic [15:0] hq;
    logic [7:0]  hr;
    logic        hdz;
    logic [15:0] rd;
    logic [7:0]  rs;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edz;
    int          a;
    int          b;

    cmp_cnt = 0; err_cnt = 0; accepts = 0; retires = 0;

    vecs[0]  = '{16'd1000,  8'd7,   16'd142,   8'd6,    1'b0, 16};
    vecs[1]  = '{16'hFFFF,  8'hFF,  16'd257,   8'd0,    1'b0, 16};
    vecs[2]  = '{16'hFFFF,  8'd1,   16'd65535, 8'd0,    1'b0, 16};
    vecs[3]  = '{16'd5,     8'd200, 16'd0,     8'd5,    1'b0, 16};
    vecs[4]  = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,   1'b1, 1};
    vecs[5]  = '{16'd100,   8'd10,  16'd10,    8'd0,    1'b0, 16};
    vecs[6]  = '{16'd0,     8'd3,   16'd0,     8'd0,    1'b0, 16};
    vecs[7]  = '{16'd255,   8'd255, 16'd1,     8'd0,    1'b0, 16};
    vecs[8]  = '{16'd256,   8'd255, 16'd1,     8'd1,    1'b0, 16};
    vecs[9]  = '{16'hFF00,  8'h80,  16'h01FE,  8'd0,    1'b0, 16};
    vecs[10] = '{16'd0,     8'd0,   16'hFFFF,  8'd0,    1'b1, 1};
    vecs[11] = '{16'd12345, 8'd254, 16'd48,    8'd153,  1'b0, 16};

    // Reset values
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_div_zero", 32'(bus.div_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, 1'b1);

    // Backpressure: result held 10 cycles, in_valid pulses ignored
    bus.out_ready = 1'b0;
    run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 1'b1);
    hq = bus.quotient; hr = bus.remainder; hdz = bus.div_zero;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.dividend = 16'h0BAD;
      bus.divisor  = 8'd3;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_quotient", 32'(bus.quotient), 32'(hq));
      check("bp_remainder", 32'(bus.remainder), 32'(hr));
      check("bp_div_zero", 32'(bus.div_zero), 32'(hdz));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    retires++;
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge clk); #1;
    check("bp_no_ghost_op", 32'(bus.in_ready), 32'd1);
    $display("backpressure sequence: held q=%0d r=%0d for 10 cycles", hq, hr);

    // Reset in the middle of CALC
    bus.in_valid = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("midrst_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_quotient", 32'(bus.quotient), 32'd0);
    check("midrst_remainder", 32'(bus.remainder), 32'd0);
    check("midrst_div_zero", 32'(bus.div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("mid-CALC reset applied");
    run_op(16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 16, 1'b1);

    // Random back-to-back operations against integer / and %
    for (int n = 0; n < 2000; n++) begin
      rd = 16'($urandom);
      rs = (n % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      a = int'(rd);
      b = int'(rs);
      if (b == 0) begin
        eq = 16'hFFFF; er = rd[7:0]; edz = 1'b1;
      end else begin
        eq = 16'(a / b); er = 8'(a % b); edz = 1'b0;
      end
      run_op(rd, rs, eq, er, edz, (b == 0) ? 1 : 16, 1'b1);
    end
    check("accepts_eq_retires", 32'(retires), 32'(accepts));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
